// File: rtl/game_io_regs_pkg.sv
// Shared definitions for the game I/O register bank: register offsets,
// IRQ source bit positions, STATUS bit positions and the decoded bus request.
package game_io_regs_pkg;

  localparam int REG_W = 16;

  typedef enum logic [2:0] {
    REG_BUTTONS     = 3'd0,
    REG_STATUS      = 3'd1,
    REG_COLLISION   = 3'd2,
    REG_PRESS       = 3'd3,
    REG_FRAME_COUNT = 3'd4,
    REG_IRQ_MASK    = 3'd5,
    REG_RSVD6       = 3'd6,
    REG_RSVD7       = 3'd7
  } reg_off_e;

  // IRQ source positions inside IRQ_MASK and the pending vector
  localparam int IRQ_W         = 3;
  localparam int IRQ_FRAME     = 0;
  localparam int IRQ_COLLISION = 1;
  localparam int IRQ_PRESS     = 2;

  // STATUS register bit positions
  localparam int STAT_VBLANK      = 0;
  localparam int STAT_FRAME_START = 1;

  // Decoded bus access, already qualified by block select
  typedef struct packed {
    logic     rd;
    logic     wr;
    reg_off_e off;
  } bus_req_t;

  // Block-select value compared against register_index[11:3]
  function automatic logic [8:0] block_sel(input int base);
    return 9'(base >> 3);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button lane: 2-flop synchroniser followed by a saturating debounce
// counter. The level flips after the synchronised pin disagrees with it for
// 2^DEBOUNCE_BITS consecutive cycles; rise flags the edge where it goes high.
module button_debouncer #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

  logic [1:0]               sync_pipe;
  logic [DEBOUNCE_BITS-1:0] cnt;
  logic                     differ;

  assign differ = sync_pipe[1] ^ level;
  // Combinational so the sticky PRESS bit sets on the same edge as the level
  assign rise   = differ && sync_pipe[1] && (cnt == CNT_MAX);

  // Synchroniser shift and debounce counter; any agreeing cycle restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pipe <= '0;
      cnt       <= '0;
      level     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], pin};
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_pipe[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_io_regs.sv
// Memory-mapped game I/O register bank: debounced buttons with sticky press
// events, vblank status with frame-start flag and frame counter, sticky
// collision flags and a masked interrupt. Reads have one-cycle latency.
module game_io_regs
  import game_io_regs_pkg::*;
#(
  parameter int NUM_BUTTONS   = 4,
  parameter int NUM_COLLISION = 6,
  parameter int DEBOUNCE_BITS = 16,
  parameter int BASE_INDEX    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [11:0]              register_index,
  input  logic                     register_read,
  input  logic                     register_write,
  input  logic [REG_W-1:0]         register_write_value,
  output logic [REG_W-1:0]         register_read_value,
  input  logic [NUM_BUTTONS-1:0]   buttons,
  input  logic                     in_vblank,
  input  logic [NUM_COLLISION-1:0] collision,
  output logic                     irq
);

  localparam logic [8:0] BASE_SEL = block_sel(BASE_INDEX);

  logic [NUM_BUTTONS-1:0]   btn_lvl, btn_rise;
  logic                     vb_q, vb_rise;
  logic                     frame_start;
  logic [NUM_COLLISION-1:0] coll_st;
  logic [NUM_BUTTONS-1:0]   press_st;
  logic [REG_W-1:0]         frame_cnt;
  logic [IRQ_W-1:0]         irq_mask, pending;
  logic [REG_W-1:0]         rd_data;
  bus_req_t                 req;

  // Per-button synchroniser + debouncer lanes
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db (
      .clk   (clk),
      .reset (reset),
      .pin   (buttons[i]),
      .level (btn_lvl[i]),
      .rise  (btn_rise[i])
    );
  end

  // Address decode: only accesses inside this block's 8-register window count
  always_comb begin
    req     = '0;
    req.off = reg_off_e'(register_index[2:0]);
    if (register_index[11:3] == BASE_SEL) begin
      req.rd = register_read;
      req.wr = register_write;
    end
  end

  // Vblank edge detect; the rise is registered so frame events land 2 cycles after the pin
  always_ff @(posedge clk) begin
    if (reset) begin
      vb_q    <= 1'b0;
      vb_rise <= 1'b0;
    end else begin
      vb_q    <= in_vblank;
      vb_rise <= in_vblank & ~vb_q;
    end
  end

  // Read mux; sticky registers include this cycle's event so nothing is lost on clear
  always_comb begin
    rd_data = '0;
    case (req.off)
      REG_BUTTONS:     rd_data[NUM_BUTTONS-1:0] = btn_lvl;
      REG_STATUS: begin
        rd_data[STAT_VBLANK]      = in_vblank;
        rd_data[STAT_FRAME_START] = frame_start | vb_rise;
      end
      REG_COLLISION:   rd_data[NUM_COLLISION-1:0] = coll_st | collision;
      REG_PRESS:       rd_data[NUM_BUTTONS-1:0] = press_st | btn_rise;
      REG_FRAME_COUNT: rd_data = frame_cnt;
      REG_IRQ_MASK:    rd_data[IRQ_W-1:0] = irq_mask;
      default:         rd_data = '0;
    endcase
  end

  // Read data register: unselected reads leave the previous value in place
  always_ff @(posedge clk) begin
    if (reset)       register_read_value <= '0;
    else if (req.rd) register_read_value <= rd_data;
  end

  // Sticky event flags: clear-on-read keeps only the event arriving that same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start <= 1'b0;
      coll_st     <= '0;
      press_st    <= '0;
    end else begin
      frame_start <= (req.rd && req.off == REG_STATUS)    ? vb_rise   : (frame_start | vb_rise);
      coll_st     <= (req.rd && req.off == REG_COLLISION) ? collision : (coll_st | collision);
      press_st    <= (req.rd && req.off == REG_PRESS)     ? btn_rise  : (press_st | btn_rise);
    end
  end

  // Frame counter and IRQ mask; a counter write overrides a coincident vblank edge
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      irq_mask  <= '0;
    end else begin
      if (req.wr && req.off == REG_FRAME_COUNT) frame_cnt <= register_write_value;
      else if (vb_rise)                         frame_cnt <= frame_cnt + 1'b1;
      if (req.wr && req.off == REG_IRQ_MASK)    irq_mask  <= register_write_value[IRQ_W-1:0];
    end
  end

  always_comb begin
    pending                = '0;
    pending[IRQ_FRAME]     = frame_start;
    pending[IRQ_COLLISION] = |coll_st;
    pending[IRQ_PRESS]     = |press_st;
  end

  // Interrupt follows the sticky state one cycle later
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(pending & irq_mask);
  end

endmodule

// File: tb/tb_game_io_regs.sv
// Scoreboard bench for game_io_regs: a behavioural model runs on each rising
// edge and queues the expected read data / irq; a monitor on the falling
// edge pops and compares. Directed scenarios first, then random traffic.
module tb_game_io_regs;

  localparam int NB   = 4;
  localparam int NC   = 6;
  localparam int DB   = 2;
  localparam int BASE = 8;
  localparam int DMAX = (1 << DB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [11:0]   register_index = '0;
  logic          register_read = 1'b0;
  logic          register_write = 1'b0;
  logic [15:0]   register_write_value = '0;
  logic [15:0]   register_read_value;
  logic [NB-1:0] buttons = '0;
  logic          in_vblank = 1'b0;
  logic [NC-1:0] collision = '0;
  logic          irq;

  game_io_regs #(
    .NUM_BUTTONS(NB), .NUM_COLLISION(NC), .DEBOUNCE_BITS(DB), .BASE_INDEX(BASE)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .buttons              (buttons),
    .in_vblank            (in_vblank),
    .collision            (collision),
    .irq                  (irq)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] rd;
    logic        irq;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state, in register-map terms
  logic [NB-1:0] pin_hist[$];   // [0] = pin one edge ago, [1] = two edges ago
  logic          vb_hist[$];
  logic [NB-1:0] m_lvl;
  int            m_streak[NB];
  logic          m_fs;
  logic [NC-1:0] m_coll;
  logic [NB-1:0] m_press;
  logic [15:0]   m_cnt;
  logic [2:0]    m_mask;
  logic [15:0]   m_rd;
  logic          m_irq;

  task automatic model_step();
    logic [NB-1:0] seen, lvl_n, press_ev;
    logic          frame_ev, rd, wr;
    logic [2:0]    off;
    obs_t          e;
    if (reset) begin
      pin_hist.delete(); pin_hist.push_back('0); pin_hist.push_back('0);
      vb_hist.delete();  vb_hist.push_back(1'b0); vb_hist.push_back(1'b0);
      m_lvl = '0; m_fs = 1'b0; m_coll = '0; m_press = '0;
      m_cnt = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
      for (int b = 0; b < NB; b++) m_streak[b] = 0;
    end else begin
      // Debounce: level flips after DMAX+1 consecutive disagreeing synchronised samples
      seen = pin_hist[1];
      lvl_n = m_lvl;
      press_ev = '0;
      for (int b = 0; b < NB; b++) begin
        if (seen[b] !== m_lvl[b]) begin
          m_streak[b]++;
          if (m_streak[b] == DMAX + 1) begin
            lvl_n[b] = seen[b];
            press_ev[b] = seen[b];
            m_streak[b] = 0;
          end
        end else begin
          m_streak[b] = 0;
        end
      end
      frame_ev = vb_hist[0] & ~vb_hist[1];
      m_irq = |({|m_press, |m_coll, m_fs} & m_mask);
      rd  = register_read  && (int'(register_index) / 8 == BASE / 8);
      wr  = register_write && (int'(register_index) / 8 == BASE / 8);
      off = register_index[2:0];
      if (rd) begin
        case (off)
          3'd0:    m_rd = 16'(m_lvl);
          3'd1:    m_rd = {14'd0, m_fs | frame_ev, in_vblank};
          3'd2:    m_rd = 16'(m_coll | collision);
          3'd3:    m_rd = 16'(m_press | press_ev);
          3'd4:    m_rd = m_cnt;
          3'd5:    m_rd = 16'(m_mask);
          default: m_rd = 16'd0;
        endcase
      end
      m_fs    = (rd && off == 3'd1) ? frame_ev  : (m_fs | frame_ev);
      m_coll  = (rd && off == 3'd2) ? collision : (m_coll | collision);
      m_press = (rd && off == 3'd3) ? press_ev  : (m_press | press_ev);
      if (wr && off == 3'd4) m_cnt = register_write_value;
      else if (frame_ev)     m_cnt = m_cnt + 16'd1;
      if (wr && off == 3'd5) m_mask = register_write_value[2:0];
      m_lvl = lvl_n;
      pin_hist.push_front(buttons); void'(pin_hist.pop_back());
      vb_hist.push_front(in_vblank); void'(vb_hist.pop_back());
    end
    e.rd  = m_rd;
    e.irq = m_irq;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: output state after each edge is compared on the falling edge
  initial forever begin : monitor
    obs_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (register_read_value !== e.rd) begin
        n_bad++;
        $display("FAIL read_value t=%0t got=%h exp=%h", $time, register_read_value, e.rd);
      end
      n_cmp++;
      if (irq !== e.irq) begin
        n_bad++;
        $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, e.irq);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    register_read  = 1'b0;
    register_write = 1'b0;
  endtask

  task automatic rd_reg(input int idx);
    register_index = 12'(idx);
    register_read  = 1'b1;
    cyc();
  endtask

  task automatic wr_reg(input int idx, input logic [15:0] v);
    register_index       = 12'(idx);
    register_write_value = v;
    register_write       = 1'b1;
    cyc();
  endtask

  initial begin : stim
    int r, k;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    for (int i = 8; i < 16; i++) rd_reg(i);

    // Debounce: hold button0, poll BUTTONS, then PRESS twice
    buttons = 4'b0001;
    repeat (8) rd_reg(8);
    rd_reg(11); rd_reg(11);
    // 3-cycle glitch on button1 must not change anything
    buttons[1] = 1'b1; repeat (3) cyc(); buttons[1] = 1'b0;
    repeat (8) rd_reg(8);
    rd_reg(11);

    // Three vblank pulses, then STATUS and FRAME_COUNT
    for (int i = 0; i < 3; i++) begin
      in_vblank = 1'b1; repeat (2) cyc();
      in_vblank = 1'b0; repeat (2) cyc();
    end
    rd_reg(9); rd_reg(12);
    wr_reg(12, 16'hFFFF);
    in_vblank = 1'b1; repeat (3) cyc(); in_vblank = 1'b0; cyc();
    rd_reg(12);
    // Counter write coincident with the counted edge
    in_vblank = 1'b1; cyc();
    wr_reg(12, 16'h1234);
    in_vblank = 1'b0; repeat (2) cyc();
    rd_reg(12); rd_reg(9);

    // Collision sticky with clear-on-read racing a new pulse
    collision = 6'b000100; cyc();
    collision = 6'b100000; rd_reg(10);
    collision = '0; rd_reg(10); rd_reg(10);

    // IRQ on collision, cleared by read; then masked off
    wr_reg(13, 16'h0002);
    collision = 6'b000001; cyc(); collision = '0;
    repeat (3) cyc();
    rd_reg(10); repeat (3) cyc();
    wr_reg(13, 16'h0000);
    collision = 6'b000010; cyc(); collision = '0;
    repeat (3) cyc(); rd_reg(10);
    // Frame-start interrupt with all sources enabled
    wr_reg(13, 16'hFFFF); rd_reg(13);
    in_vblank = 1'b1; repeat (4) cyc(); rd_reg(9); cyc(); in_vblank = 1'b0;
    wr_reg(13, 16'h0000);

    // Decode boundaries
    rd_reg(0); rd_reg(9); wr_reg(8, 16'hFFFF); rd_reg(8);
    wr_reg(14, 16'hABCD); rd_reg(14); rd_reg(15); rd_reg(7); rd_reg(16);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        k = $urandom_range(0, NB - 1);
        buttons[k] = ~buttons[k];
      end
      if ($urandom_range(0, 5) == 0) in_vblank = ~in_vblank;
      collision = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
      r = $urandom_range(0, 9);
      if (r < 4)       rd_reg($urandom_range(0, 23));
      else if (r == 4) wr_reg($urandom_range(4, 17), 16'($urandom));
      else             cyc();
      if (c == 700) begin
        reset = 1'b1; cyc(); reset = 1'b0;
      end
    end

    repeat (3) cyc();
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
